multiciclo_core: RTL and testbench

//  Multicycle successor to the single-cycle RV32I datapath: one shared memory port, an FSM per instruction, and a parametrised register file.

---
 rtl/multiciclo_core.sv | 246 ++++++++++++++++++++++++
 tb/tb_multiciclo_core.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiciclo_core.sv
`default_nettype none
// ============================================================================
//  Module   : multiciclo_core
//  Purpose  : Multicycle RV32I subset core (R-ALU, I-ALU, LW, SW, BEQ/BNE)
//             with one shared memory port, one FSM pass per instruction and a
//             parametrised register file. Unsupported opcodes or register
//             indices >= NREGS halt the core until reset.
//  Params   : NREGS    - GPR count (16 or 32)
//             RESET_PC - PC value after reset
//  Ports    : clk_i, rst_ni         - clock / async active-low reset
//             mem_req_o, mem_we_o   - memory request / write enable
//             mem_addr_o            - word-aligned byte address
//             mem_wdata_o           - store data (rs2)
//             mem_rdata_i           - read data, valid with mem_ready_i
//             mem_ready_i           - transfer completes when req & ready
//             instret_o             - retired count (MULTICICLO_INSTRET_EN)
//             monitor_o             - last value written back
//             halt_o                - core stopped on illegal instruction
//  Config   : define MULTICICLO_INSTRET_EN to add the instret_o counter
//  Revision : 1.0 - initial release
// ============================================================================
module multiciclo_core #(
    parameter int          NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic [31:0] monitor_o,
`ifdef MULTICICLO_INSTRET_EN
    output logic [31:0] instret_o,
`endif
    output logic        halt_o
);

    localparam int         RIDX_W    = $clog2(NREGS);
    localparam logic [6:0] OP_R_ALU  = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      state;
    logic [31:0] pc, ir, opa, opb, imm, tgt, aluout, mdr, monitor;
    logic        halt;
    logic [31:0] gpr [NREGS];

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        funct7_b5;
    assign opcode    = ir[6:0];
    assign rd        = ir[11:7];
    assign funct3    = ir[14:12];
    assign rs1       = ir[19:15];
    assign rs2       = ir[24:20];
    assign funct7_b5 = ir[30];

    logic is_r, is_i, is_load, is_store, is_branch;
    assign is_r      = (opcode == OP_R_ALU);
    assign is_i      = (opcode == OP_I_ALU);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);

    function automatic logic idx_ok(input logic [4:0] idx);
        return {27'd0, idx} < 32'(NREGS);
    endfunction

    // Only the register fields a format actually uses are range-checked.
    logic uses_rd, uses_rs2, decode_ok;
    assign uses_rd   = is_r || is_i || is_load;
    assign uses_rs2  = is_r || is_store || is_branch;
    assign decode_ok = (is_r || is_i || is_load || is_store || is_branch)
                    && idx_ok(rs1)
                    && (!uses_rs2 || idx_ok(rs2))
                    && (!uses_rd  || idx_ok(rd));

    // Immediate generation; B-immediate carries bit0 = 0 already.
    logic [31:0] imm_dec;
    always_comb begin
        imm_dec = {{20{ir[31]}}, ir[31:20]};
        if (is_store) begin
            imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        end else if (is_branch) begin
            imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        end
    end

    // x0 is never written, so gpr[0] always holds zero.
    logic [31:0] rs1_val, rs2_val;
    assign rs1_val = gpr[rs1[RIDX_W-1:0]];
    assign rs2_val = gpr[rs2[RIDX_W-1:0]];

    // ALU. funct7[5] selects SUB only for R-type ADD, and SRA/SRAI for
    // funct3=101; for ADDI the same bit is just immediate data.
    logic [31:0] op_b, alu_res;
    logic        alt_op;
    assign op_b   = is_r ? opb : imm;
    assign alt_op = funct7_b5 && ((is_r && funct3 == 3'b000) || funct3 == 3'b101);

    always_comb begin
        alu_res = opa + op_b;
        if (is_r || is_i) begin
            case (funct3)
                3'b000:  alu_res = alt_op ? (opa - op_b) : (opa + op_b);
                3'b001:  alu_res = opa << op_b[4:0];
                3'b010:  alu_res = {31'd0, $signed(opa) < $signed(op_b)};
                3'b011:  alu_res = {31'd0, opa < op_b};
                3'b100:  alu_res = opa ^ op_b;
                3'b101: begin
                    if (alt_op) alu_res = $signed(opa) >>> op_b[4:0];
                    else        alu_res = opa >> op_b[4:0];
                end
                3'b110:  alu_res = opa | op_b;
                default: alu_res = opa & op_b;
            endcase
        end
    end

    logic        br_taken;
    logic [31:0] wb_val;
    assign br_taken = (opa == opb) ^ funct3[0];
    assign wb_val   = is_load ? mdr : aluout;

    // Main FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            opa     <= '0;
            opb     <= '0;
            imm     <= '0;
            tgt     <= '0;
            aluout  <= '0;
            mdr     <= '0;
            monitor <= '0;
            halt    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready_i) begin
                        ir    <= mem_rdata_i;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!decode_ok) begin
                        halt  <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        opa   <= rs1_val;
                        opb   <= rs2_val;
                        imm   <= imm_dec;
                        tgt   <= pc + imm_dec;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    aluout <= alu_res;
                    if (is_branch) begin
                        pc    <= br_taken ? tgt : pc + 32'd4;
                        state <= S_FETCH;
                    end else if (is_load || is_store) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready_i) begin
                        if (is_store) begin
                            pc    <= pc + 32'd4;
                            state <= S_FETCH;
                        end else begin
                            mdr   <= mem_rdata_i;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    monitor <= wb_val;
                    pc      <= pc + 32'd4;
                    state   <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

    // Register file
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                gpr[i] <= '0;
            end
        end else if (state == S_WB && rd != 5'd0) begin
            gpr[rd[RIDX_W-1:0]] <= wb_val;
        end
    end

`ifdef MULTICICLO_INSTRET_EN
    logic        retire;
    logic [31:0] instret;
    assign retire = (state == S_WB)
                 || (state == S_EXEC && is_branch)
                 || (state == S_MEM && is_store && mem_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 32'd1;
        end
    end
    assign instret_o = instret;
`endif

    // The request is gated by reset so an in-flight transfer is abandoned
    // the moment reset asserts, not at the next clock.
    assign mem_req_o   = rst_ni && (state == S_FETCH || state == S_MEM);
    assign mem_we_o    = rst_ni && (state == S_MEM) && is_store;
    assign mem_addr_o  = {(state == S_MEM) ? aluout[31:2] : pc[31:2], 2'b00};
    assign mem_wdata_o = opb;
    assign monitor_o   = monitor;
    assign halt_o      = halt;

endmodule
`default_nettype wire

// File: tb/tb_multiciclo_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multiciclo_core
//  Purpose  : Directed self-checking bench for multiciclo_core; a second
//             instance with NREGS=16 exercises illegal register indices.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multiciclo_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req, we, ready, halt;
    logic [31:0] addr, wdata, rdata, monitor;
    logic        req16, we16, ready16, halt16;
    logic [31:0] addr16, wdata16, rdata16, monitor16;
`ifdef MULTICICLO_INSTRET_EN
    logic [31:0] instret, instret16;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multiciclo_core #(.NREGS(32), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata),
        .mem_rdata_i(rdata), .mem_ready_i(ready), .monitor_o(monitor),
`ifdef MULTICICLO_INSTRET_EN
        .instret_o(instret),
`endif
        .halt_o(halt)
    );

    multiciclo_core #(.NREGS(16), .RESET_PC(32'h0)) dut16 (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_req_o(req16), .mem_we_o(we16), .mem_addr_o(addr16), .mem_wdata_o(wdata16),
        .mem_rdata_i(rdata16), .mem_ready_i(ready16), .monitor_o(monitor16),
`ifdef MULTICICLO_INSTRET_EN
        .instret_o(instret16),
`endif
        .halt_o(halt16)
    );

    // Stimulus helpers (drive only)
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic respond(input logic [31:0] data);
        ready = 1'b1;
        rdata = data;
        @(negedge clk);
        ready = 1'b0;
        rdata = 32'h0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ready = 1'b1;
        #1;
        checks++;
        if (req !== 1'b0 || we !== 1'b0 || halt !== 1'b0 || monitor !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: req=%b we=%b halt=%b mon=%h, want 0 0 0 0", req, we, halt, monitor);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (req !== 1'b0 || halt !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: req=%b halt=%b, want 0 0", req, halt);
        end
        ready = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req !== 1'b1 || addr !== 32'h0 || we !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_fetch: req=%b addr=%h we=%b, want 1 0 0", req, addr, we);
        end
`ifdef MULTICICLO_INSTRET_EN
        checks++;
        if (instret !== 32'd0) begin
            failures++;
            $display("FAIL reset_instret: got %0d want 0", instret);
        end
`endif
    endtask

    task automatic test_alu();
        logic [31:0] prog [3];
        logic [31:0] mon  [3];
        prog = '{32'h00500093, 32'h00700113, 32'h002081B3};
        mon  = '{32'd5, 32'd7, 32'd12};
        for (int i = 0; i < 3; i++) begin
            respond(prog[i]);
            checks++;
            if (req !== 1'b0) begin
                failures++;
                $display("FAIL alu_decode_idle%0d: req=%b want 0", i, req);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (req !== 1'b1 || addr !== 32'(4 * (i + 1)) || monitor !== mon[i]) begin
                failures++;
                $display("FAIL alu_seq%0d: req=%b addr=%h mon=%h, want 1 %h %h",
                         i, req, addr, monitor, 32'(4 * (i + 1)), mon[i]);
            end
        end
`ifdef MULTICICLO_INSTRET_EN
        checks++;
        if (instret !== 32'd3) begin
            failures++;
            $display("FAIL alu_instret: got %0d want 3", instret);
        end
`endif
    endtask

    task automatic test_load_store();
        logic [31:0] stored;
        stored = 32'h0;
        respond(32'h00302423);                 // sw x3,8(x0) at 0x0C
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req !== 1'b1 || we !== 1'b1 || addr !== 32'h8 || wdata !== 32'd12) begin
                failures++;
                $display("FAIL sw_req%0d: req=%b we=%b addr=%h wdata=%h, want 1 1 8 c",
                         i, req, we, addr, wdata);
            end
            if (i == 3) begin
                ready  = 1'b1;
                stored = wdata;
            end
            @(negedge clk);
        end
        ready = 1'b0;
        checks++;
        if (req !== 1'b1 || we !== 1'b0 || addr !== 32'h10) begin
            failures++;
            $display("FAIL sw_next_fetch: req=%b we=%b addr=%h, want 1 0 10", req, we, addr);
        end
        respond(32'h00802203);                 // lw x4,8(x0) at 0x10
        repeat (2) @(negedge clk);
        checks++;
        if (req !== 1'b1 || we !== 1'b0 || addr !== 32'h8) begin
            failures++;
            $display("FAIL lw_req: req=%b we=%b addr=%h, want 1 0 8", req, we, addr);
        end
        repeat (3) @(negedge clk);
        respond(stored);
        checks++;
        if (req !== 1'b0) begin
            failures++;
            $display("FAIL lw_wb_idle: req=%b want 0", req);
        end
        @(negedge clk);
        checks++;
        if (req !== 1'b1 || addr !== 32'h14 || monitor !== 32'd12) begin
            failures++;
            $display("FAIL lw_result: req=%b addr=%h mon=%h, want 1 14 c", req, addr, monitor);
        end
`ifdef MULTICICLO_INSTRET_EN
        checks++;
        if (instret !== 32'd5) begin
            failures++;
            $display("FAIL ls_instret: got %0d want 5", instret);
        end
`endif
    endtask

    task automatic test_branch();
        logic [31:0] prog [5];
        logic [31:0] nxt  [5];
        prog = '{32'h00109863, 32'h00000663, 32'hFE108CE3, 32'h00000463, 32'h00109863};
        nxt  = '{32'h04, 32'h10, 32'h08, 32'h10, 32'h14};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            respond(prog[i]);
            @(negedge clk);
            checks++;
            if (req !== 1'b0) begin
                failures++;
                $display("FAIL br_exec_idle%0d: req=%b want 0", i, req);
            end
            @(negedge clk);
            checks++;
            if (req !== 1'b1 || addr !== nxt[i]) begin
                failures++;
                $display("FAIL br_target%0d: req=%b addr=%h, want 1 %h", i, req, addr, nxt[i]);
            end
        end
`ifdef MULTICICLO_INSTRET_EN
        checks++;
        if (instret !== 32'd5) begin
            failures++;
            $display("FAIL br_instret: got %0d want 5", instret);
        end
`endif
    endtask

    task automatic test_x0_halt();
        respond(32'h00900013);                 // addi x0,x0,9
        repeat (3) @(negedge clk);
        checks++;
        if (monitor !== 32'd9 || addr !== 32'h18) begin
            failures++;
            $display("FAIL x0_monitor: mon=%h addr=%h, want 9 18", monitor, addr);
        end
        respond(32'h000002B3);                 // add x5,x0,x0
        repeat (3) @(negedge clk);
        checks++;
        if (monitor !== 32'd0 || addr !== 32'h1C) begin
            failures++;
            $display("FAIL x0_reads_zero: mon=%h addr=%h, want 0 1c", monitor, addr);
        end
        respond(32'h00000000);
        checks++;
        if (halt !== 1'b0) begin
            failures++;
            $display("FAIL halt_early: halt=%b want 0", halt);
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (halt !== 1'b1 || req !== 1'b0) begin
                failures++;
                $display("FAIL halt_absorb%0d: halt=%b req=%b, want 1 0", i, halt, req);
            end
        end
        ready = 1'b0;
`ifdef MULTICICLO_INSTRET_EN
        checks++;
        if (instret !== 32'd7) begin
            failures++;
            $display("FAIL halt_instret: got %0d want 7", instret);
        end
`endif
    endtask

    task automatic test_alu_ops();
        logic [31:0] prog [7];
        logic [31:0] mon  [7];
        prog = '{32'hFFD00093, 32'h4010D193, 32'h00103233, 32'h001022B3,
                 32'h40100333, 32'hFFF00393, 32'h01C0D413};
        mon  = '{32'hFFFFFFFD, 32'hFFFFFFFE, 32'h1, 32'h0,
                 32'h3, 32'hFFFFFFFF, 32'hF};
        do_reset();
        #1;
        checks++;
        if (req !== 1'b1 || halt !== 1'b0) begin
            failures++;
            $display("FAIL rst_clears_halt: req=%b halt=%b, want 1 0", req, halt);
        end
`ifdef MULTICICLO_INSTRET_EN
        checks++;
        if (instret !== 32'd0) begin
            failures++;
            $display("FAIL rst_instret: got %0d want 0", instret);
        end
`endif
        rst_n = 1'b0;
        #1;
        checks++;
        if (req !== 1'b0) begin
            failures++;
            $display("FAIL rst_drops_req: req=%b want 0", req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            respond(prog[i]);
            repeat (3) @(negedge clk);
            checks++;
            if (monitor !== mon[i] || addr !== 32'(4 * (i + 1))) begin
                failures++;
                $display("FAIL alu_op%0d: mon=%h addr=%h, want %h %h",
                         i, monitor, addr, mon[i], 32'(4 * (i + 1)));
            end
        end
    endtask

    task automatic test_nregs();
        do_reset();
        ready16 = 1'b1;
        rdata16 = 32'h00100793;                // addi x15,x0,1
        @(negedge clk);
        ready16 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (monitor16 !== 32'd1 || addr16 !== 32'h4 || halt16 !== 1'b0) begin
            failures++;
            $display("FAIL nregs_x15: mon=%h addr=%h halt=%b, want 1 4 0", monitor16, addr16, halt16);
        end
        ready16 = 1'b1;
        rdata16 = 32'h00100A13;                // addi x20,x0,1
        @(negedge clk);
        ready16 = 1'b0;
        @(negedge clk);
        checks++;
        if (halt16 !== 1'b1 || req16 !== 1'b0 || monitor16 !== 32'd1) begin
            failures++;
            $display("FAIL nregs_x20_halt: halt=%b req=%b mon=%h, want 1 0 1", halt16, req16, monitor16);
        end
    endtask

    initial begin
        ready   = 1'b0;
        rdata   = 32'h0;
        ready16 = 1'b0;
        rdata16 = 32'h0;
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_x0_halt();
        test_alu_ops();
        test_nregs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
